// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: digit encoding and
// helpers that size the partial-product array and the per-stage reduction share.
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  function automatic int calc_npp(input int width);
    return (width + 2) / 2;
  endfunction

  // Stage 1 only registers partial products, so the remaining stages split the adds.
  function automatic int calc_share(input int width, input int stages);
    int npp;
    npp = calc_npp(width);
    if (stages <= 1) return npp;
    return (npp + stages - 2) / (stages - 1);
  endfunction

  function automatic booth_digit_e booth_recode(input logic [2:0] trip);
    booth_digit_e d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth recoder and partial-product generator.
// Each partial product is sign-extended to the full product width and pre-shifted.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]                           data1,
  input  logic [WIDTH-1:0]                           data2,
  input  logic                                       signed1,
  input  logic                                       signed2,
  output logic [calc_npp(WIDTH)-1:0][2*WIDTH-1:0]    pp
);

  localparam int E   = WIDTH + 2;
  localparam int NPP = calc_npp(WIDTH);

  logic [E-1:0] ext1;
  logic [E:0]   ext2z;
  logic [E:0]   m1;
  logic [E:0]   m2;

  // The extra low zero bit of ext2z stands in for the implicit bit below the LSB.
  assign ext1  = {{2{signed1 & data1[WIDTH-1]}}, data1};
  assign ext2z = {{2{signed2 & data2[WIDTH-1]}}, data2, 1'b0};
  assign m1    = {ext1[E-1], ext1};
  assign m2    = {ext1, 1'b0};

  for (genvar j = 0; j < NPP; j++) begin : g_pp
    booth_digit_e dig;
    logic [E:0]   mval;

    assign dig = booth_recode(ext2z[2*j+2 -: 3]);

    always_comb begin
      mval = '0;
      case (dig)
        POS1:    mval = m1;
        POS2:    mval = m2;
        NEG1:    mval = -m1;
        NEG2:    mval = -m2;
        default: mval = '0;
      endcase
    end

    assign pp[j] = {{(2*WIDTH-E-1){mval[E]}}, mval} << (2*j);
  end

endmodule

// File: rtl/booth_mul_pipe.sv
// Elastic radix-4 Booth multiplier: stage 1 registers partial products, later
// stages accumulate an equal share each; a tag travels with every product.
module booth_mul_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  input  logic               signed1,
  input  logic               signed2,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               flush,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2*WIDTH-1:0] res,
  output logic [TAG_W-1:0]   tag_o
);

  localparam int NPP   = calc_npp(WIDTH);
  localparam int SHARE = calc_share(WIDTH, STAGES);
  localparam int PW    = 2 * WIDTH;
  localparam int PPS   = (STAGES > 1) ? STAGES - 1 : 1;

  logic [NPP-1:0][PW-1:0] pp_comb;
  logic [NPP-1:0][PW-1:0] pp_q  [1:PPS];
  logic [PW-1:0]          acc_q [1:STAGES];
  logic [TAG_W-1:0]       tag_q [1:STAGES];
  logic [STAGES:1]        valid_q;
  logic [STAGES:1]        valid_in;
  logic [STAGES+1:1]      rdy;

  booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .data1   (data1),
    .data2   (data2),
    .signed1 (signed1),
    .signed2 (signed2),
    .pp      (pp_comb)
  );

  assign rdy[STAGES+1] = ready_i;
  assign ready_o       = rdy[1] & ~flush;
  assign valid_in[1]   = valid_i & ~flush;
  assign valid_o       = valid_q[STAGES];
  assign res           = acc_q[STAGES];
  assign tag_o         = tag_q[STAGES];

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    assign rdy[k] = ~valid_q[k] | rdy[k+1];

    if (k > 1) begin : g_vin
      assign valid_in[k] = valid_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      valid_q[k] <= 1'b0;
      else if (flush)  valid_q[k] <= 1'b0;
      else if (rdy[k]) valid_q[k] <= valid_in[k];
    end

    if (k == 1) begin : g_first
      logic [PW-1:0] sum_all;

      always_comb begin
        sum_all = '0;
        for (int j = 0; j < NPP; j++) sum_all = sum_all + pp_comb[j];
      end

      // With a single stage the whole product is formed here; otherwise acc starts at zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q[1] <= '0;
          tag_q[1] <= '0;
          pp_q[1]  <= '0;
        end else if (valid_in[1] && rdy[1]) begin
          acc_q[1] <= (STAGES == 1) ? sum_all : '0;
          tag_q[1] <= tag_i;
          pp_q[1]  <= pp_comb;
        end
      end
    end else begin : g_reduce
      localparam int LO = (k - 2) * SHARE;
      localparam int HI = ((k - 1) * SHARE < NPP) ? (k - 1) * SHARE : NPP;
      logic [PW-1:0] acc_next;

      always_comb begin
        acc_next = acc_q[k-1];
        for (int j = 0; j < NPP; j++) begin
          if (j >= LO && j < HI) acc_next = acc_next + pp_q[k-1][j];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q[k] <= '0;
          tag_q[k] <= '0;
        end else if (valid_in[k] && rdy[k]) begin
          acc_q[k] <= acc_next;
          tag_q[k] <= tag_q[k-1];
        end
      end

      if (k < STAGES) begin : g_pass
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)                    pp_q[k] <= '0;
          else if (valid_in[k] && rdy[k]) pp_q[k] <= pp_q[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Self-checking bench for booth_mul_pipe: a scoreboard of reference products
// checked at every output handshake, plus directed latency/stall/flush scenarios.
module tb_booth_mul_pipe;

  localparam int W = 32;
  localparam int S = 3;
  localparam int T = 4;

  logic             clk;
  logic             rst_n;
  logic             valid_i;
  logic             ready_o;
  logic [W-1:0]     data1;
  logic [W-1:0]     data2;
  logic             signed1;
  logic             signed2;
  logic [T-1:0]     tag_i;
  logic             flush;
  logic             valid_o;
  logic             ready_i;
  logic [2*W-1:0]   res;
  logic [T-1:0]     tag_o;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic [T-1:0]   tag;
  } exp_t;

  exp_t           sb[$];
  int             tests = 0;
  int             fails = 0;
  int             out_count = 0;
  int             mode = 0;
  logic           flush_req = 1'b0;
  logic [3:0]     pat = 4'b1001;
  logic           prev_stall = 1'b0;
  logic [2*W-1:0] prev_res;
  logic [T-1:0]   prev_tag;

  booth_mul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data1   (data1),
    .data2   (data2),
    .signed1 (signed1),
    .signed2 (signed2),
    .tag_i   (tag_i),
    .flush   (flush),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res     (res),
    .tag_o   (tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sa, input logic sb_);
    logic [2*W-1:0] xa;
    logic [2*W-1:0] xb;
    xa = sa  ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = sb_ ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  // Downstream ready and flush are driven from one place, 2 time units after each edge.
  initial begin
    int phase;
    phase   = 0;
    ready_i = 1'b1;
    flush   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        1: begin ready_i = pat[phase % 4]; phase++; end
        2: ready_i = ($urandom_range(0, 2) != 0);
        3: ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
      flush = (mode == 2) ? ($urandom_range(0, 39) == 0) : flush_req;
    end
  end

  // Scoreboard monitor sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (!(valid_o === 1'b1 && res === prev_res && tag_o === prev_tag)) begin
          fails++;
          $display("[TB] FAIL stall_hold: valid_o=%b res=%h tag=%h, required valid_o=1 res=%h tag=%h",
                   valid_o, res, tag_o, prev_res, prev_tag);
        end
      end
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        out_count++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_output: res=%h tag=%h, required no output", res, tag_o);
        end else begin
          e = sb.pop_front();
          if (res !== e.res || tag_o !== e.tag) begin
            fails++;
            $display("[TB] FAIL result: res=%h tag=%h, required res=%h tag=%h", res, tag_o, e.res, e.tag);
          end
        end
      end
      if (flush) sb.delete();
      if (valid_i === 1'b1 && ready_o === 1'b1) begin
        e.res = model(data1, data2, signed1, signed2);
        e.tag = tag_i;
        sb.push_back(e);
      end
      prev_stall = (valid_o === 1'b1) && !ready_i && !flush;
      prev_res   = res;
      prev_tag   = tag_o;
    end
  end

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s1, input logic s2, input logic [T-1:0] t);
    logic ok;
    ok      = 1'b0;
    valid_i = 1'b1;
    data1   = a;
    data2   = b;
    signed1 = s1;
    signed2 = s2;
    tag_i   = t;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: ready_o=%b, required 1 within 500 cycles", ready_o);
    end
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (valid_o !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || valid_o === 1'b1) && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    tests++;
    if (sb.size() != 0 || valid_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL drain: pending=%0d valid_o=%b, required 0 and 0", sb.size(), valid_o);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data1   = '0;
    data2   = '0;
    signed1 = 1'b0;
    signed2 = 1'b0;
    tag_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (valid_o !== 1'b0 || res !== '0 || tag_o !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state: valid_o=%b res=%h tag=%h, required 0/0/0", valid_o, res, tag_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (ready_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready: ready_o=%b, required 1", ready_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int cyc;
    mode = 0;
    drive_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 4'd5);
    wait_valid(cyc);
    cyc++;
    tests++;
    if (cyc != S) begin
      fails++;
      $display("[TB] FAIL latency: got %0d cycles, required %0d", cyc, S);
    end
    tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE || tag_o !== 4'd5) begin
      fails++;
      $display("[TB] FAIL neg1_x_2: res=%h tag=%h, required FFFFFFFFFFFFFFFE tag 5", res, tag_o);
    end
    wait_drain();
  endtask

  task automatic test_extension();
    int cyc;
    drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd1);
    wait_valid(cyc);
    tests++;
    if (res !== 64'hFFFF_FFFE_0000_0001) begin
      fails++;
      $display("[TB] FAIL uu_ones: res=%h, required FFFFFFFE00000001", res);
    end
    wait_drain();
    drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd2);
    wait_valid(cyc);
    tests++;
    if (res !== 64'hFFFF_FFFF_0000_0001) begin
      fails++;
      $display("[TB] FAIL su_ones: res=%h, required FFFFFFFF00000001", res);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int start;
    start = out_count;
    mode  = 1;
    for (int i = 0; i < 8; i++)
      drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), T'(i));
    mode = 0;
    wait_drain();
    tests++;
    if (out_count - start != 8) begin
      fails++;
      $display("[TB] FAIL b2b_count: got %0d outputs, required 8", out_count - start);
    end
  endtask

  task automatic test_fill();
    mode = 3;
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) drive_op($urandom, $urandom, 1'b1, 1'b0, T'(i + 3));
    tests++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fill_full: ready_o=%b valid_o=%b, required 0 and 1", ready_o, valid_o);
    end
    valid_i = 1'b1;
    data1   = 32'h1234_5678;
    data2   = 32'h8765_4321;
    signed1 = 1'b1;
    signed2 = 1'b1;
    tag_i   = 4'hE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (ready_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL fill_blocked: ready_o=%b, required 0", ready_o);
      end
      @(posedge clk);
      #1;
    end
    mode = 0;
    for (int i = 0; i < S + 1; i++) begin
      @(negedge clk);
      tests++;
      if (valid_o !== 1'b1) begin
        fails++;
        $display("[TB] FAIL release_rate: cycle %0d valid_o=%b, required 1", i, valid_o);
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
    end
    wait_drain();
  endtask

  task automatic test_flush();
    int cyc;
    mode = 3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive_op($urandom, $urandom, 1'b0, 1'b1, T'(i + 8));
    flush_req = 1'b1;
    valid_i   = 1'b1;
    @(negedge clk);
    tests++;
    if (ready_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_ready: ready_o=%b, required 0", ready_o);
    end
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    valid_i   = 1'b0;
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_kill: valid_o=%b, required 0", valid_o);
    end
    mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (valid_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL flush_quiet: valid_o=%b, required 0", valid_o);
      end
    end
    drive_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd9);
    wait_valid(cyc);
    tests++;
    if (res !== 64'h4000_0000_0000_0000 || tag_o !== 4'd9) begin
      fails++;
      $display("[TB] FAIL min_x_min: res=%h tag=%h, required 4000000000000000 tag 9", res, tag_o);
    end
    wait_drain();
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    mode = 2;
    for (int i = 0; i < 300; i++)
      drive_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), T'(i));
    mode = 0;
    wait_drain();
  endtask

  task automatic test_reset_midop();
    mode = 3;
    @(posedge clk);
    #1;
    drive_op($urandom, $urandom, 1'b1, 1'b1, 4'd7);
    drive_op($urandom, $urandom, 1'b0, 1'b0, 4'd6);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_midop: valid_o=%b ready_o=%b, required 0 and 1", valid_o, ready_o);
    end
    rst_n = 1'b1;
    mode  = 0;
    repeat (S + 2) @(posedge clk);
    #1;
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_discard: valid_o=%b, required 0", valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_extension();
    test_back_to_back();
    test_fill();
    test_flush();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
